// File: rtl/ch_aggregator_if.sv
// ----------------------------------------------------------------------------
// ch_aggregator_if
// Groups the control and memory-bus signals of the cluster-head aggregation
// stage. Clock and reset stay outside as plain ports.
//
// Signals:
//   en             global enable; low freezes the aggregator
//   start          start pulse, honoured only while the aggregator is idle
//   forAggregation 1 when this node is cluster head
//   data_in        memory read data, valid one cycle after address changes
//   address        memory address (registered in the aggregator)
//   wr_en          memory write strobe
//   data_out       memory write data (registered in the aggregator)
//   done           one-cycle completion pulse
//
// Modports:
//   master  environment side (controller + memory) driving the aggregator
//   slave   the aggregator itself
// ----------------------------------------------------------------------------
interface ch_aggregator_if;
    logic        en;
    logic        start;
    logic        forAggregation;
    logic [15:0] data_in;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        done;

    modport master (
        output en, start, forAggregation, data_in,
        input  address, wr_en, data_out, done
    );

    modport slave (
        input  en, start, forAggregation, data_in,
        output address, wr_en, data_out, done
    );
endinterface

// File: rtl/ch_aggregator.sv
// ----------------------------------------------------------------------------
// ch_aggregator
// Cluster-head data aggregation stage. On a cluster-head node it reads the
// member-packet count and the buffered member payloads from the shared data
// memory, reduces them to a saturating sum and an unsigned maximum, and writes
// a 3-word record (sum, max, {sat, 7'b0, N}) at OUT_BASE. On a non-cluster-head
// node it only pulses done.
//
// Handshake: start is a level sampled on a rising edge while the block is IDLE
// and en is high; done is high for exactly one cycle when the operation
// completes. en low freezes every register; wr_en is forced low meanwhile.
//
// Ports:
//   clock        sole clock, rising edge
//   nrst         synchronous active-low reset
//   bus          ch_aggregator_if.slave (control + memory bus)
//   o_dbg_state  current FSM state encoding, for observation only
// ----------------------------------------------------------------------------
module ch_aggregator #(
    parameter logic [10:0] COUNT_ADDR  = 11'h010,
    parameter logic [10:0] BUF_BASE    = 11'h020,
    parameter logic [10:0] OUT_BASE    = 11'h100,
    parameter logic [7:0]  MAX_MEMBERS = 8'd16
) (
    input  logic            clock,
    input  logic            nrst,
    ch_aggregator_if.slave  bus,
    output logic [3:0]      o_dbg_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_CNT  = 4'd1,
        CAP_CNT = 4'd2,
        RD_DAT  = 4'd3,
        CAP_DAT = 4'd4,
        WR_SUM  = 4'd5,
        WR_MAX  = 4'd6,
        WR_CNT  = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t      r_state, w_state_nx;
    logic [10:0] r_addr,  w_addr_nx;
    logic [15:0] r_dout,  w_dout_nx;
    logic        r_wr,    w_wr_nx;
    logic        r_done,  w_done_nx;
    logic [15:0] r_sum,   w_sum_nx;
    logic [15:0] r_max,   w_max_nx;
    logic [7:0]  r_n,     w_n_nx;
    logic [7:0]  r_idx,   w_idx_nx;
    logic        r_sat,   w_sat_nx;

    logic [16:0] w_add;
    logic        w_add_ovf;
    logic [15:0] w_sum_sat;
    logic [15:0] w_max_cap;
    logic        w_clamped;
    logic [7:0]  w_n_clamp;
    logic [7:0]  w_idx_inc;

    // Datapath helpers evaluated against the word currently on data_in.
    assign w_add     = {1'b0, r_sum} + {1'b0, bus.data_in};
    assign w_add_ovf = w_add[16];
    assign w_sum_sat = w_add_ovf ? 16'hFFFF : w_add[15:0];
    assign w_max_cap = (bus.data_in > r_max) ? bus.data_in : r_max;
    assign w_clamped = (bus.data_in > {8'd0, MAX_MEMBERS});
    assign w_n_clamp = w_clamped ? MAX_MEMBERS : bus.data_in[7:0];
    assign w_idx_inc = r_idx + 8'd1;

    // State and datapath registers. en low holds everything, including the
    // IDLE sampling of start.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_addr  <= 11'd0;
            r_dout  <= 16'd0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= 16'd0;
            r_max   <= 16'd0;
            r_n     <= 8'd0;
            r_idx   <= 8'd0;
            r_sat   <= 1'b0;
        end else if (bus.en) begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_dout  <= w_dout_nx;
            r_wr    <= w_wr_nx;
            r_done  <= w_done_nx;
            r_sum   <= w_sum_nx;
            r_max   <= w_max_nx;
            r_n     <= w_n_nx;
            r_idx   <= w_idx_nx;
            r_sat   <= w_sat_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_dout_nx  = r_dout;
        w_wr_nx    = r_wr;
        w_done_nx  = r_done;
        w_sum_nx   = r_sum;
        w_max_nx   = r_max;
        w_n_nx     = r_n;
        w_idx_nx   = r_idx;
        w_sat_nx   = r_sat;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.forAggregation) begin
                        // Enter DONE with the pulse not yet armed; DONE raises
                        // it one edge later.
                        w_state_nx = DONE;
                    end else begin
                        w_addr_nx  = COUNT_ADDR;
                        w_sum_nx   = 16'd0;
                        w_max_nx   = 16'd0;
                        w_idx_nx   = 8'd0;
                        w_sat_nx   = 1'b0;
                        w_state_nx = RD_CNT;
                    end
                end
            end

            RD_CNT: w_state_nx = CAP_CNT;

            CAP_CNT: begin
                w_n_nx   = w_n_clamp;
                // A clamped count is flagged in the same bit as sum overflow.
                w_sat_nx = w_clamped;
                if (w_n_clamp != 8'd0) begin
                    w_addr_nx  = BUF_BASE;
                    w_state_nx = RD_DAT;
                end else begin
                    w_wr_nx    = 1'b1;
                    w_addr_nx  = OUT_BASE;
                    w_dout_nx  = r_sum;
                    w_state_nx = WR_SUM;
                end
            end

            RD_DAT: w_state_nx = CAP_DAT;

            CAP_DAT: begin
                w_sum_nx = w_sum_sat;
                w_sat_nx = r_sat | w_add_ovf;
                w_max_nx = w_max_cap;
                w_idx_nx = w_idx_inc;
                if (w_idx_inc < r_n) begin
                    w_addr_nx  = r_addr + 11'd1;
                    w_state_nx = RD_DAT;
                end else begin
                    // The sum written here already includes the last word.
                    w_wr_nx    = 1'b1;
                    w_addr_nx  = OUT_BASE;
                    w_dout_nx  = w_sum_sat;
                    w_state_nx = WR_SUM;
                end
            end

            WR_SUM: begin
                w_addr_nx  = OUT_BASE + 11'd1;
                w_dout_nx  = r_max;
                w_state_nx = WR_MAX;
            end

            WR_MAX: begin
                w_addr_nx  = OUT_BASE + 11'd2;
                w_dout_nx  = {r_sat, 7'd0, r_n};
                w_state_nx = WR_CNT;
            end

            WR_CNT: begin
                w_wr_nx    = 1'b0;
                w_done_nx  = 1'b1;
                w_state_nx = DONE;
            end

            DONE: begin
                if (r_done) begin
                    w_done_nx  = 1'b0;
                    w_state_nx = IDLE;
                end else begin
                    w_done_nx  = 1'b1;
                end
            end

            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.address  = r_addr;
    assign bus.wr_en    = r_wr & bus.en;
    assign bus.data_out = r_dout;
    assign bus.done     = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/ch_aggregator.md
# ch_aggregator

- Cluster-head data aggregation stage. Sits directly downstream of the cluster-head decision block and consumes its `forAggregation` flag.
- When started on a cluster-head node, it reads the member-packet count and the buffered member payloads from the node's shared 2048-word data memory.
- It reduces the payloads to a saturating sum and a maximum, then writes a 3-word aggregate record back to memory for the uplink stage.
- On a non-cluster-head node it completes immediately and writes nothing.

## Interface
- `COUNT_ADDR`, 11'h010: memory address of the member-packet count word.
- `BUF_BASE`, 11'h020: address of the first buffered member payload word.
- `OUT_BASE`, 11'h100: address of the first aggregate-record word.
- `MAX_MEMBERS`, 16: clamp for the member count (≤255).

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `nrst`  in  1  synchronous, active-low reset.
- `en`  in  1  global enable; low freezes the block.
- `start`  in  1  start pulse, sampled in IDLE only.
- `forAggregation`  in  1  from the cluster-head decision stage; 1 means this node is cluster head.
- `data_in`  in  16  memory read data; valid one cycle after `address` changes.
- `address`  out  11  memory address (registered).
- `wr_en`  out  1  memory write strobe, equal to the internal write register AND `en`.
- `data_out`  out  16  memory write data (registered).
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reset (`nrst`=0 at an edge) sets state=IDLE, `address`=0, `data_out`=0, `wr_en`=0, `done`=0, sum=0, max=0, N=0, idx=0, sat=0. Applies mid-operation too; no partial record is completed.
- IDLE, `en`=1, `start`=1:
  - If `forAggregation`=0: go to DONE. No reads, no writes.
  - If `forAggregation`=1: `address`←`COUNT_ADDR`, clear sum/max/idx/sat, go to RD_CNT.
- RD_CNT → CAP_CNT (wait cycle for memory).
- CAP_CNT:
  - N ← min(`data_in`, `MAX_MEMBERS`), 8-bit.
  - If N>0: `address`←`BUF_BASE`, go to RD_DAT. If N=0: go to WR_SUM.
- RD_DAT → CAP_DAT (wait cycle).
- CAP_DAT:
  - sum ← sum + `data_in`, saturating at 16'hFFFF; sat←1 if the addition saturates.
  - max ← max(max, `data_in`), unsigned.
  - idx++.
  - If idx+1<N: `address`++, go to RD_DAT. Otherwise go to WR_SUM.
- Entering WR_SUM: `wr_en`=1, `address`=`OUT_BASE`, `data_out`=final sum. The final sum includes the word captured on that same edge.
- WR_MAX: `address`=`OUT_BASE`+1, `data_out`=max.
- WR_CNT: `address`=`OUT_BASE`+2, `data_out`={sat, 7'b0, N}.
- DONE: `wr_en`=0, `done`=1 for exactly one cycle, then IDLE. Record registers keep their values until the next start.
- `start` outside IDLE is ignored.
- `en`=0: state and all registers hold; `wr_en` output is 0; `start` is ignored. Resuming `en` continues exactly where the block stopped.

## Timing
- Memory read latency is 1 cycle, so each word read costs 2 cycles.
- With start sampled at edge E0 (cluster head, N members):
  - Count latched at E2.
  - WR_SUM entered at E(2+2N).
  - `done` high during the cycle after edge E(5+2N). Total 2N+5 cycles.
- Non-cluster-head: `done` high during the cycle after E1; 1-cycle latency.
- Each write cycle presents `wr_en`, `address` and `data_out` together for exactly one cycle.
- The clamp and the sum saturation are both reported in bit 15 of the count word (`sat`).

## Test plan
- Reset mid-run: assert `nrst`=0 during RD_DAT → next cycle all outputs 0, state IDLE, no further writes. A new start then runs normally.
- Not cluster head: `forAggregation`=0, `start` pulse → `done`=1 one cycle after the start edge, `wr_en` never asserted.
- N=3, payloads 5, 9, 2 → writes at 0x100=5+9+2=16 (0x0010), 0x101=0x0009, 0x102=0x0003. `done` after edge 11.
- N=0 → three writes of 0, 0, 0x0000. `done` after edge 5.
- Saturation and clamp: count word=20 with all payloads 0x2000 → N clamped to 16, sum=0xFFFF, max=0x2000, count word=0x8010. Exactly 16 payload reads.
- `en` low for 3 cycles mid-read, plus a second `start` while busy → the record is identical to the uninterrupted run, `done` is delayed by exactly 3 cycles, and the extra start has no effect.
